// File: rtl/avalon_tester_pkg.sv
// Shared types and helpers for the Avalon-MM burst self-test master.
package avalon_tester_pkg;

   localparam int unsigned DEF_BURSTCOUNT_W = 6;
   localparam int unsigned DEF_ERR_W        = 16;
   localparam logic [31:0] DEF_SEED         = 32'hA5A5_0000;
   localparam int unsigned ADDR_W           = 32;
   localparam int unsigned DATA_W           = 32;
   localparam int unsigned NB_BURSTS_W      = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_BURST,
      S_RD_CMD,
      S_RD_DATA,
      S_DONE
   } state_e;

   // Largest legal burst for a given burstcount width.
   function automatic int unsigned max_burst_size(input int unsigned bc_w);
      return 32'd1 << (bc_w - 32'd1);
   endfunction

   function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] seed,
                                                 input logic [DATA_W-1:0] idx);
      return seed + idx;
   endfunction

endpackage

// File: rtl/avalon_burst_tester_addr_gen.sv
// Burst index / beat counter and burst base address, shared by write and read phases.
module burst_addr_gen
   import avalon_tester_pkg::*;
#(
   parameter int unsigned AV_BURSTCOUNT_W = DEF_BURSTCOUNT_W
)(
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_clear,
   input  logic [ADDR_W-1:0]          i_base,
   input  logic                       i_beat_adv,
   input  logic [AV_BURSTCOUNT_W-1:0] i_burst_len,
   input  logic [NB_BURSTS_W-1:0]     i_nb_bursts,
   output logic [ADDR_W-1:0]          o_address,
   output logic                       o_last_beat_c,
   output logic                       o_last_burst_c
);

   logic [AV_BURSTCOUNT_W-1:0] r_beat;
   logic [NB_BURSTS_W-1:0]     r_burst;

   assign o_last_beat_c  = (r_beat == i_burst_len - AV_BURSTCOUNT_W'(1));
   assign o_last_burst_c = (r_burst == i_nb_bursts - NB_BURSTS_W'(1));

   // Address steps by one burst footprint, so it stays constant across a burst's beats.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_beat    <= '0;
         r_burst   <= '0;
         o_address <= '0;
      end else if (i_clear) begin
         r_beat    <= '0;
         r_burst   <= '0;
         o_address <= i_base;
      end else if (i_beat_adv) begin
         if (o_last_beat_c) begin
            r_beat    <= '0;
            r_burst   <= r_burst + NB_BURSTS_W'(1);
            o_address <= o_address + (ADDR_W'(i_burst_len) << 2);
         end else begin
            r_beat <= r_beat + AV_BURSTCOUNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/avalon_burst_tester.sv
// Avalon-MM burst master: writes a seeded pattern over a region, reads it back, counts mismatches.
module avalon_burst_tester
   import avalon_tester_pkg::*;
#(
   parameter int unsigned       AV_BURSTCOUNT_W = DEF_BURSTCOUNT_W,
   parameter int unsigned       ERR_W           = DEF_ERR_W,
   parameter logic [DATA_W-1:0] SEED            = DEF_SEED
)(
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_start,
   input  logic [ADDR_W-1:0]          i_base_addr,
   input  logic [AV_BURSTCOUNT_W-1:0] i_burst_len,
   input  logic [NB_BURSTS_W-1:0]     i_nb_bursts,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_bad_cfg,
   output logic [ERR_W-1:0]           o_error_count,
   output logic [ADDR_W-1:0]          o_address,
   output logic [AV_BURSTCOUNT_W-1:0] o_burstcount,
   output logic [3:0]                 o_byteenable,
   output logic                       o_read,
   output logic                       o_write,
   output logic [DATA_W-1:0]          o_writedata,
   input  logic [DATA_W-1:0]          i_readdata,
   input  logic                       i_readdatavalid,
   input  logic                       i_waitrequest
);

   localparam int unsigned MAX_BURST_SIZE = max_burst_size(AV_BURSTCOUNT_W);

   state_e                 r_state, w_state_nxt;
   logic [ADDR_W-1:0]      r_base;
   logic [NB_BURSTS_W-1:0] r_nb;
   logic [DATA_W-1:0]      r_idx;

   logic                   w_cfg_bad, w_start_ok, w_start_bad;
   logic                   w_wr_acc, w_rd_acc, w_rd_beat, w_wr_end;
   logic                   w_last_beat, w_last_burst;
   logic [ADDR_W-1:0]      w_base_in;
   logic                   w_write_nxt, w_read_nxt, w_done_nxt;
   logic [DATA_W-1:0]      w_idx_nxt, w_wdata_nxt;
   logic [ERR_W-1:0]       w_err_nxt;

   assign w_cfg_bad   = (i_burst_len == '0) || (i_nb_bursts == '0) ||
                        (i_burst_len > AV_BURSTCOUNT_W'(MAX_BURST_SIZE));
   assign w_start_ok  = (r_state == S_IDLE) && i_start && !w_cfg_bad;
   assign w_start_bad = (r_state == S_IDLE) && i_start && w_cfg_bad;
   assign w_wr_acc    = (r_state == S_WR_BURST) && o_write && !i_waitrequest;
   assign w_rd_acc    = (r_state == S_RD_CMD) && o_read && !i_waitrequest;
   assign w_rd_beat   = (r_state == S_RD_DATA) && i_readdatavalid;
   assign w_wr_end    = w_wr_acc && w_last_beat && w_last_burst;
   assign w_base_in   = w_start_ok ? (i_base_addr & ~ADDR_W'(3)) : r_base;

   burst_addr_gen #(
      .AV_BURSTCOUNT_W (AV_BURSTCOUNT_W)
   ) u_addr_gen (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_clear        (w_start_ok || w_wr_end),
      .i_base         (w_base_in),
      .i_beat_adv     (w_wr_acc || w_rd_beat),
      .i_burst_len    (o_burstcount),
      .i_nb_bursts    (r_nb),
      .o_address      (o_address),
      .o_last_beat_c  (w_last_beat),
      .o_last_burst_c (w_last_burst)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:     if (w_start_bad) w_state_nxt = S_DONE;
                     else if (w_start_ok) w_state_nxt = S_WR_BURST;
         S_WR_BURST: if (w_wr_end) w_state_nxt = S_RD_CMD;
         S_RD_CMD:   if (w_rd_acc) w_state_nxt = S_RD_DATA;
         S_RD_DATA:  if (w_rd_beat && w_last_beat)
                        w_state_nxt = w_last_burst ? S_DONE : S_RD_CMD;
         S_DONE:     w_state_nxt = S_IDLE;
         default:    w_state_nxt = S_IDLE;
      endcase
   end

   // Next values of the registered outputs; strobes lag state entry by one cycle.
   always_comb begin
      w_write_nxt = (r_state == S_WR_BURST) && !w_wr_end;
      w_read_nxt  = (r_state == S_RD_CMD) && !w_rd_acc;
      w_done_nxt  = (r_state == S_DONE);
      w_idx_nxt   = r_idx;
      w_err_nxt   = o_error_count;
      if (w_start_ok || w_wr_end)
         w_idx_nxt = '0;
      else if (w_wr_acc || w_rd_beat)
         w_idx_nxt = r_idx + DATA_W'(1);
      if (w_start_ok)
         w_err_nxt = '0;
      else if (w_rd_beat && (i_readdata != pattern(SEED, r_idx)) && (o_error_count != '1))
         w_err_nxt = o_error_count + ERR_W'(1);
      w_wdata_nxt = (r_state == S_WR_BURST) ? pattern(SEED, w_idx_nxt) : o_writedata;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_write       <= 1'b0;
         o_read        <= 1'b0;
         o_done        <= 1'b0;
         o_busy        <= 1'b0;
         o_bad_cfg     <= 1'b0;
         o_writedata   <= '0;
         o_error_count <= '0;
         o_burstcount  <= '0;
         o_byteenable  <= '0;
         r_idx         <= '0;
         r_base        <= '0;
         r_nb          <= '0;
      end else begin
         o_write       <= w_write_nxt;
         o_read        <= w_read_nxt;
         o_done        <= w_done_nxt;
         o_writedata   <= w_wdata_nxt;
         o_error_count <= w_err_nxt;
         r_idx         <= w_idx_nxt;
         if (w_start_ok) begin
            r_base       <= w_base_in;
            r_nb         <= i_nb_bursts;
            o_burstcount <= i_burst_len;
            o_byteenable <= 4'hF;
            o_bad_cfg    <= 1'b0;
            o_busy       <= 1'b1;
         end else begin
            if (w_start_bad) o_bad_cfg <= 1'b1;
            if (o_done)      o_busy    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_avalon_burst_tester.sv
// Directed bench for avalon_burst_tester with a behavioural burst slave (read latency ~3).
module tb_avalon_burst_tester;

   localparam logic [31:0] SEED = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1, start = 1'b0;
   logic [31:0] base_addr = '0;
   logic [5:0]  burst_len = '0;
   logic [15:0] nb_bursts = '0;
   logic        busy, done, bad_cfg, av_read, av_write;
   logic [15:0] error_count;
   logic [31:0] address, writedata;
   logic [5:0]  burstcount;
   logic [3:0]  byteenable;
   logic [31:0] readdata = '0;
   logic        readdatavalid = 1'b0, waitrequest = 1'b0;

   int n_checks = 0, n_errors = 0;

   always #5 clk = ~clk;

   avalon_burst_tester dut (
      .i_clk           (clk),
      .i_reset         (reset),
      .i_start         (start),
      .i_base_addr     (base_addr),
      .i_burst_len     (burst_len),
      .i_nb_bursts     (nb_bursts),
      .o_busy          (busy),
      .o_done          (done),
      .o_bad_cfg       (bad_cfg),
      .o_error_count   (error_count),
      .o_address       (address),
      .o_burstcount    (burstcount),
      .o_byteenable    (byteenable),
      .o_read          (av_read),
      .o_write         (av_write),
      .o_writedata     (writedata),
      .i_readdata      (readdata),
      .i_readdatavalid (readdatavalid),
      .i_waitrequest   (waitrequest)
   );

   // Controls owned by the main sequence
   int clr_seq = 0, corrupt_idx = -1;
   bit corrupt_all = 1'b0, wait_rand = 1'b0, spur_en = 1'b0;

   // State and logs owned by the slave model
   logic [31:0] mem [0:255];
   logic [31:0] rq [$];
   logic [31:0] wr_data [0:63];
   logic [31:0] wr_addr [0:63];
   logic [31:0] rd_addr [0:7];
   int rd_delay, wb_left, wb_off, wb_base, wr_n, rd_n, rd_push_n, stall_viol, s_seq;
   logic s_reset, s_wacc, s_racc, p_stall;
   logic [75:0] s_cmd, p_cmd;
   logic [31:0] s_addr, s_wd, v;
   logic [5:0]  s_bc;

   initial begin
      for (int k = 0; k < 256; k++) mem[k] = '0;
      rd_delay = 0; wb_left = 0; wb_off = 0; wb_base = 0; wr_n = 0; rd_n = 0;
      rd_push_n = 0; stall_viol = 0; s_seq = 0; p_stall = 1'b0; p_cmd = '0;
      forever begin
         @(posedge clk);
         s_reset = reset;
         s_wacc  = av_write && !waitrequest;
         s_racc  = av_read && !waitrequest;
         s_addr  = address; s_wd = writedata; s_bc = burstcount;
         s_cmd   = {av_write, av_read, address, burstcount, byteenable, writedata};
         if (p_stall && (s_cmd !== p_cmd)) stall_viol++;
         p_stall = (av_write || av_read) && waitrequest && !reset;
         p_cmd   = s_cmd;
         #1;
         readdatavalid = 1'b0;
         if (clr_seq != s_seq) begin
            s_seq = clr_seq; wr_n = 0; rd_n = 0; rd_push_n = 0; stall_viol = 0;
         end
         if (s_reset) begin
            rq.delete(); wb_left = 0; rd_delay = 0;
         end else begin
            if (s_wacc) begin
               if (wb_left == 0) begin
                  wb_base = int'(s_addr[9:2]); wb_left = int'(s_bc); wb_off = 0;
               end
               mem[(wb_base + wb_off) % 256] = s_wd;
               if (wr_n < 64) begin wr_data[wr_n] = s_wd; wr_addr[wr_n] = s_addr; end
               wr_n++; wb_off++; wb_left--;
            end
            if (s_racc) begin
               if (rd_n < 8) rd_addr[rd_n] = s_addr;
               rd_n++;
               for (int k = 0; k < int'(s_bc); k++) begin
                  v = mem[(int'(s_addr[9:2]) + k) % 256];
                  if (corrupt_all || rd_push_n == corrupt_idx) v = v ^ 32'h0000_0100;
                  rq.push_back(v);
                  rd_push_n++;
               end
               rd_delay = 2;
            end
            if (rq.size() > 0) begin
               if (rd_delay > 0) rd_delay--;
               else begin readdata = rq.pop_front(); readdatavalid = 1'b1; end
            end else if (spur_en && av_write) begin
               readdata = 32'hDEAD_BEEF; readdatavalid = 1'b1;
            end
         end
         waitrequest = wait_rand ? 1'($urandom_range(0, 1)) : 1'b0;
      end
   end

   task automatic clear_logs();
      clr_seq++;
      @(posedge clk); #2;
   endtask

   task automatic start_req(input logic [31:0] b, input logic [5:0] l, input logic [15:0] n);
      base_addr = b; burst_len = l; nb_bursts = n; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
   endtask

   task automatic wait_done(output bit timed_out);
      int cyc = 0;
      while (!done && cyc < 3000) begin @(posedge clk); #2; cyc++; end
      timed_out = !done;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #2;
      n_checks += 6;
      if (busy !== 1'b0)        begin n_errors++; $display("FAIL reset_busy: got %0h want 0", busy); end
      if (done !== 1'b0)        begin n_errors++; $display("FAIL reset_done: got %0h want 0", done); end
      if (bad_cfg !== 1'b0)     begin n_errors++; $display("FAIL reset_bad_cfg: got %0h want 0", bad_cfg); end
      if (error_count !== 16'd0) begin n_errors++; $display("FAIL reset_err: got %0h want 0", error_count); end
      if ({av_read, av_write} !== 2'b00) begin n_errors++; $display("FAIL reset_rw: got %0h want 0", {av_read, av_write}); end
      if ({address, writedata, burstcount, byteenable} !== 74'd0) begin
         n_errors++; $display("FAIL reset_cmd: got %0h want 0", {address, writedata, burstcount, byteenable});
      end
      reset = 1'b0;
      @(posedge clk); #2;
      n_checks++;
      if ({busy, av_write, av_read} !== 3'b000) begin n_errors++; $display("FAIL idle_after_reset: got %0h want 0", {busy, av_write, av_read}); end
   endtask

   task automatic test_basic();
      bit to;
      clear_logs();
      start_req(32'h0, 6'd4, 16'd2);
      n_checks += 2;
      if (busy !== 1'b1)     begin n_errors++; $display("FAIL basic_busy_c1: got %0h want 1", busy); end
      if (av_write !== 1'b0) begin n_errors++; $display("FAIL basic_write_c1: got %0h want 0", av_write); end
      @(posedge clk); #2;
      n_checks += 2;
      if ({av_write, burstcount, byteenable} !== {1'b1, 6'd4, 4'hF}) begin
         n_errors++; $display("FAIL basic_cmd_c2: got %0h want %0h", {av_write, burstcount, byteenable}, {1'b1, 6'd4, 4'hF});
      end
      if ({address, writedata} !== {32'h0, SEED}) begin
         n_errors++; $display("FAIL basic_first_beat: got %0h want %0h", {address, writedata}, {32'h0, SEED});
      end
      wait_done(to);
      n_checks += 5;
      if (to)                   begin n_errors++; $display("FAIL basic_timeout: got done=%0h want 1", done); end
      if (error_count !== 16'd0) begin n_errors++; $display("FAIL basic_err: got %0d want 0", error_count); end
      if (busy !== 1'b1)        begin n_errors++; $display("FAIL basic_busy_done: got %0h want 1", busy); end
      if (wr_n != 8)            begin n_errors++; $display("FAIL basic_wr_n: got %0d want 8", wr_n); end
      if (rd_n != 2)            begin n_errors++; $display("FAIL basic_rd_n: got %0d want 2", rd_n); end
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (wr_data[i] !== SEED + 32'(i) || wr_addr[i] !== ((i < 4) ? 32'h0 : 32'h10)) begin
            n_errors++;
            $display("FAIL basic_wr_beat%0d: got %0h@%0h want %0h@%0h", i, wr_data[i], wr_addr[i],
                     SEED + 32'(i), (i < 4) ? 32'h0 : 32'h10);
         end
      end
      n_checks++;
      if (rd_addr[0] !== 32'h0 || rd_addr[1] !== 32'h10) begin
         n_errors++; $display("FAIL basic_rd_addr: got %0h,%0h want 0,10", rd_addr[0], rd_addr[1]);
      end
      @(posedge clk); #2;
      n_checks++;
      if ({busy, done} !== 2'b00) begin n_errors++; $display("FAIL basic_after_done: got %0h want 0", {busy, done}); end
   endtask

   task automatic test_waitrequest();
      bit to;
      int bad;
      clear_logs();
      wait_rand = 1'b1;
      start_req(32'h0, 6'd4, 16'd2);
      wait_done(to);
      wait_rand = 1'b0;
      bad = 0;
      for (int i = 0; i < 8; i++) if (wr_data[i] !== SEED + 32'(i)) bad++;
      n_checks += 5;
      if (to)                    begin n_errors++; $display("FAIL wait_timeout: got done=%0h want 1", done); end
      if (wr_n != 8 || bad != 0) begin n_errors++; $display("FAIL wait_wr_data: got n=%0d bad=%0d want n=8 bad=0", wr_n, bad); end
      if (stall_viol != 0)       begin n_errors++; $display("FAIL wait_stall_hold: got %0d changes want 0", stall_viol); end
      if (rd_n != 2 || rd_addr[1] !== 32'h10) begin n_errors++; $display("FAIL wait_rd: got n=%0d a1=%0h want 2,10", rd_n, rd_addr[1]); end
      if (error_count !== 16'd0) begin n_errors++; $display("FAIL wait_err: got %0d want 0", error_count); end
      @(posedge clk); #2;
   endtask

   task automatic test_corrupt();
      bit to;
      clear_logs();
      corrupt_idx = 5;
      start_req(32'h0, 6'd4, 16'd2);
      wait_done(to);
      corrupt_idx = -1;
      n_checks += 2;
      if (to)                    begin n_errors++; $display("FAIL corrupt1_timeout: got done=%0h want 1", done); end
      if (error_count !== 16'd1) begin n_errors++; $display("FAIL corrupt1_err: got %0d want 1", error_count); end
      @(posedge clk); #2;
      clear_logs();
      corrupt_all = 1'b1;
      start_req(32'h80, 6'd32, 16'd1);
      wait_done(to);
      corrupt_all = 1'b0;
      n_checks += 4;
      if (to)                     begin n_errors++; $display("FAIL corrupt32_timeout: got done=%0h want 1", done); end
      if (error_count !== 16'd32) begin n_errors++; $display("FAIL corrupt32_err: got %0d want 32", error_count); end
      if (wr_n != 32 || wr_data[31] !== SEED + 32'd31) begin
         n_errors++; $display("FAIL corrupt32_wr: got n=%0d last=%0h want 32,%0h", wr_n, wr_data[31], SEED + 32'd31);
      end
      if (rd_n != 1 || rd_addr[0] !== 32'h80) begin n_errors++; $display("FAIL corrupt32_rd: got n=%0d a=%0h want 1,80", rd_n, rd_addr[0]); end
      @(posedge clk); #2;
   endtask

   task automatic test_bad_cfg();
      logic [5:0]  lens [3] = '{6'd0, 6'd33, 6'd4};
      logic [15:0] nbs  [3] = '{16'd2, 16'd2, 16'd0};
      for (int c = 0; c < 3; c++) begin
         clear_logs();
         start_req(32'h0, lens[c], nbs[c]);
         n_checks++;
         if ({busy, done} !== 2'b00) begin n_errors++; $display("FAIL bad%0d_c1: got %0h want 0", c, {busy, done}); end
         @(posedge clk); #2;
         n_checks += 2;
         if ({done, bad_cfg, busy} !== 3'b110) begin n_errors++; $display("FAIL bad%0d_c2: got %0b want 110", c, {done, bad_cfg, busy}); end
         if (error_count !== 16'd32) begin n_errors++; $display("FAIL bad%0d_err_held: got %0d want 32", c, error_count); end
         @(posedge clk); #2;
         @(posedge clk); #2;
         n_checks++;
         if (done !== 1'b0 || bad_cfg !== 1'b1 || wr_n != 0 || rd_n != 0) begin
            n_errors++; $display("FAIL bad%0d_after: got done=%0h bad=%0h wr=%0d rd=%0d want 0,1,0,0", c, done, bad_cfg, wr_n, rd_n);
         end
      end
   endtask

   task automatic test_ignored();
      bit to;
      clear_logs();
      spur_en = 1'b1;
      start_req(32'h0, 6'd4, 16'd2);
      n_checks++;
      if ({bad_cfg, error_count} !== 17'd0) begin n_errors++; $display("FAIL ign_start_clear: got %0h want 0", {bad_cfg, error_count}); end
      base_addr = 32'h200; burst_len = 6'd1; nb_bursts = 16'd1; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      spur_en = 1'b0;
      wait_done(to);
      n_checks += 3;
      if (to)                    begin n_errors++; $display("FAIL ign_timeout: got done=%0h want 1", done); end
      if (error_count !== 16'd0) begin n_errors++; $display("FAIL ign_err: got %0d want 0", error_count); end
      if (wr_n != 8 || rd_n != 2 || rd_addr[1] !== 32'h10) begin
         n_errors++; $display("FAIL ign_traffic: got wr=%0d rd=%0d a1=%0h want 8,2,10", wr_n, rd_n, rd_addr[1]);
      end
      @(posedge clk); #2;
   endtask

   task automatic test_reset_mid();
      bit to;
      int cyc = 0;
      clear_logs();
      start_req(32'h40, 6'd4, 16'd2);
      while (rd_n < 2 && cyc < 500) begin @(posedge clk); #2; cyc++; end
      n_checks++;
      if (rd_n < 2) begin n_errors++; $display("FAIL rstmid_reach_rd1: got rd_n=%0d want 2", rd_n); end
      reset = 1'b1;
      @(posedge clk); #2;
      reset = 1'b0;
      n_checks += 2;
      if ({busy, done, bad_cfg, av_read, av_write, error_count} !== 21'd0) begin
         n_errors++; $display("FAIL rstmid_status: got %0h want 0", {busy, done, bad_cfg, av_read, av_write, error_count});
      end
      if ({address, writedata, burstcount, byteenable} !== 74'd0) begin
         n_errors++; $display("FAIL rstmid_cmd: got %0h want 0", {address, writedata, burstcount, byteenable});
      end
      repeat (6) @(posedge clk);
      #2;
      n_checks++;
      if ({done, busy, error_count} !== 18'd0) begin n_errors++; $display("FAIL rstmid_quiet: got %0h want 0", {done, busy, error_count}); end
      clear_logs();
      start_req(32'h40, 6'd4, 16'd2);
      wait_done(to);
      n_checks += 3;
      if (to)                    begin n_errors++; $display("FAIL rstmid_rerun_timeout: got done=%0h want 1", done); end
      if (error_count !== 16'd0) begin n_errors++; $display("FAIL rstmid_rerun_err: got %0d want 0", error_count); end
      if (wr_n != 8 || rd_addr[0] !== 32'h40 || rd_addr[1] !== 32'h50) begin
         n_errors++; $display("FAIL rstmid_rerun_traffic: got wr=%0d a0=%0h a1=%0h want 8,40,50", wr_n, rd_addr[0], rd_addr[1]);
      end
      @(posedge clk); #2;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_waitrequest();
      test_corrupt();
      test_bad_cfg();
      test_ignored();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no completion want finish before 2ms");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/avalon_burst_tester.md
# avalon_burst_tester

Avalon-MM burst master placed directly upstream of the `avalon_bram` slave; it exercises the slave by writing a deterministic pattern over a configured region in fixed-length bursts, reading the whole region back in bursts, and counting mismatches. It drives the slave's address/burst/read/write inputs and consumes `readdata`/`readdatavalid`/`waitrequest`. Used as the on-chip self-test stage in synthesis builds of the memory controller.

## Interface
- `AV_BURSTCOUNT_W`, 6, burstcount width; `MAX_BURST_SIZE` = 2**(AV_BURSTCOUNT_W-1) = 32 beats
- `ERR_W`, 16, width of error counter
- `SEED`, 32'hA5A5_0000, pattern base value
- `clk` in 1 — single clock, all logic on rising edge
- `reset` in 1 — synchronous, active-high
- `start` in 1 — one-cycle request, sampled only in IDLE
- `base_addr` in 32 — byte address of first word, sampled with `start`; bits [1:0] forced to 0
- `burst_len` in AV_BURSTCOUNT_W — beats per burst, sampled with `start`
- `nb_bursts` in 16 — number of bursts, sampled with `start`
- `busy` out 1 — test in progress
- `done` out 1 — one-cycle completion pulse
- `bad_cfg` out 1 — last request rejected; held until next accepted `start`
- `error_count` out ERR_W — mismatches of last run, saturating, held until next accepted `start`
- `address` out 32, `burstcount` out AV_BURSTCOUNT_W, `byteenable` out 4, `read` out 1, `write` out 1, `writedata` out 32 — Avalon-MM master command side
- `readdata` in 32, `readdatavalid` in 1, `waitrequest` in 1 — Avalon-MM master response side

## Operation
- States: IDLE, WR_BURST, RD_CMD, RD_DATA, DONE.
- IDLE: on `start`, if `burst_len`==0 or `burst_len`>MAX_BURST_SIZE or `nb_bursts`==0 → set `bad_cfg`, go DONE without bus activity; else latch config, clear `error_count` and `bad_cfg`, zero word index and burst index, go WR_BURST.
- Pattern: word index i (0 .. burst_len*nb_bursts-1) has data SEED + i, modulo 2**32.
- WR_BURST: `write`=1, `byteenable`=4'hF, `burstcount`=latched `burst_len`, `address`=base_addr + 4*burst_len*burst_index (constant for all beats of a burst), `writedata`=pattern(i). A beat is accepted when `write` & !`waitrequest`; then i and beat counter advance. After last beat of a burst, next burst starts the following cycle (write stays high). After last beat of last burst → RD_CMD with burst index and i reset to 0.
- RD_CMD: `read`=1, `address`/`burstcount` as above; held until !`waitrequest`, then → RD_DATA. Exactly one read burst outstanding.
- RD_DATA: `read`=0; each `readdatavalid` compares `readdata` with pattern(i), increments `error_count` on mismatch (saturates at 2**ERR_W-1), advances i. After burst_len beats: more bursts → RD_CMD, else → DONE.
- DONE: `done`=1 for one cycle → IDLE.
- `readdatavalid` outside RD_DATA is ignored; `start` outside IDLE is ignored.
- Address arithmetic 32-bit, wraps modulo 2**32; no range check against slave size.

## Timing
- Reset values: `busy`=0, `done`=0, `bad_cfg`=0, `error_count`=0, `read`=0, `write`=0, `address`=0, `burstcount`=0, `byteenable`=0, `writedata`=0.
- Reset mid-operation: FSM to IDLE next edge, all outputs to reset values, outstanding read data discarded.
- `busy` high from the cycle after accepted `start` through the DONE cycle inclusive; not asserted for `bad_cfg` requests, which pulse `done` 2 cycles after `start`.
- All master outputs registered; `write`/`read` asserted the cycle after entering the state.
- With `waitrequest`=0 and slave read latency L, run time ≈ 2 + N + nb_bursts*(1+L+burst_len) cycles, N = total words.
- `waitrequest` stall: all command outputs hold unchanged.

## Structure
- Package `avalon_tester_pkg`: state enum, `MAX_BURST_SIZE` derivation, pattern function `pattern(seed, i)`.
- One sub-module `burst_addr_gen`: holds burst index and beat counter, produces `address`, last-beat and last-burst flags; shared by write and read phases.

## Test plan
- Reset then `start`, base_addr=0, burst_len=4, nb_bursts=2, ideal slave → 8 writes data A5A5_0000..A5A5_0007, reads at 0x0 and 0x10, `done` with `error_count`=0.
- Random `waitrequest` 50% on same config → outputs stable during stalls, same data, `error_count`=0.
- Slave corrupts read word 5 → `error_count`=1; corrupt all 32 words of burst_len=32, nb_bursts=1 → 32.
- burst_len=0, then burst_len=33 → no `read`/`write`, `bad_cfg`=1, `done` pulses 2 cycles after `start`, `busy` stays 0.
- `reset` asserted during RD_DATA of burst 1 → next cycle all outputs at reset values; later `start` runs cleanly.
- `start` pulsed while `busy` and spurious `readdatavalid` in WR_BURST → ignored, result unchanged.
